// File: rtl/mont_pkg.sv
// Shared constants and FSM state type for the wide add/sub controller.
package mont_pkg;

  localparam int K_DEF      = 256;
  localparam int W_DEF      = 32;
  localparam int NCHUNK_DEF = K_DEF / W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_adder.sv
// K-bit adder built from 4-bit carry-lookahead groups, group carries chained.
module cla_adder #(
  parameter int K = 32
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  input  logic         cin_i,
  output logic [K-1:0] sum_o,
  output logic         cout_o
);

  localparam int NG = K / 4;

  if ((K % 4) != 0 || K < 4) begin : g_bad_width
    $error("cla_adder: K must be a positive multiple of 4");
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic       cin_g;
    logic       cout_g;
    logic [3:0] p;
    logic [3:0] gn;
    logic [4:0] c;

    if (g == 0) begin : g_first
      assign cin_g = cin_i;
    end else begin : g_chain
      assign cin_g = g_grp[g-1].cout_g;
    end

    assign p  = a_i[4*g +: 4] ^ b_i[4*g +: 4];
    assign gn = a_i[4*g +: 4] & b_i[4*g +: 4];

    // Every carry is a flat function of the group inputs and cin_g.
    assign c[0] = cin_g;
    assign c[1] = gn[0] | (p[0] & cin_g);
    assign c[2] = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & cin_g);
    assign c[3] = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0])
                | (p[2] & p[1] & p[0] & cin_g);
    assign c[4] = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1])
                | (p[3] & p[2] & p[1] & gn[0])
                | (p[3] & p[2] & p[1] & p[0] & cin_g);

    assign sum_o[4*g +: 4] = p ^ c[3:0];
    assign cout_g          = c[4];
  end

  assign cout_o = g_grp[NG-1].cout_g;

endmodule

// File: rtl/wide_add_ctrl.sv
// Multi-cycle K-bit add/subtract through one W-bit CLA slice, one chunk per cycle.
// state | meaning: IDLE waiting for start | RUN one chunk per cycle | DONE result valid, one cycle
module wide_add_ctrl
  import mont_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] sum,
  output logic         cout
);

  localparam int NCHUNK = K / W;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((K % W) != 0 || (W % 4) != 0) begin : g_bad_params
    $error("wide_add_ctrl: K must be a multiple of W and W a multiple of 4");
  end

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [K-1:0]    a_q, a_d;
  logic [K-1:0]    b_q, b_d;
  logic [K-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [W-1:0]    a_chunk, b_chunk, slice_sum;
  logic            slice_cout;
  logic            last_chunk;

  assign a_chunk    = a_q[idx_q*W +: W];
  assign b_chunk    = b_q[idx_q*W +: W];
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  cla_adder #(.K(W)) u_slice (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*W +: W] = slice_sum;
        carry_d             = slice_cout;
        idx_d               = idx_q + 1'b1;
        if (last_chunk) begin
          idx_d   = '0;
          cout_d  = slice_cout;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_ctrl.sv
// Self-checking bench: arithmetic/timing model compared every cycle, plus literal pins.
module tb_wide_add_ctrl;
  import mont_pkg::*;

  localparam int K      = K_DEF;
  localparam int W      = W_DEF;
  localparam int NCHUNK = NCHUNK_DEF;
  localparam int NRAND  = 3000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [K-1:0] a = '0;
  logic [K-1:0] b = '0;
  logic         busy, done, cout;
  logic [K-1:0] sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wide_add_ctrl #(.K(K), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string name, input logic [K-1:0] got, input logic [K-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [K-1:0] x, input logic [K-1:0] y, input bit s,
                                 output logic [K-1:0] r, output bit c);
    logic [K:0] wide;
    if (s) begin
      r = x - y;
      c = (x >= y);
    end else begin
      wide = {1'b0, x} + {1'b0, y};
      r    = wide[K-1:0];
      c    = wide[K];
    end
  endfunction

  function automatic logic [K-1:0] rand_k();
    logic [K-1:0] r;
    r = '0;
    for (int i = 0; i < K / 32; i++) r[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 9))
      0: r = '0;
      1: r = '1;
      default: ;
    endcase
    return r;
  endfunction

  // Model: an accepted op is busy for NCHUNK cycles, then the result shows for one done cycle.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [K-1:0] m_sum = '0;
  bit           m_cout = 1'b0;
  logic [K-1:0] p_sum = '0;
  bit           p_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_sum  = p_sum;
          m_cout = p_cout;
        end
      end else if (start) begin
        m_left = NCHUNK;
        ref_op(a, b, sub, p_sum, p_cout);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", K'(busy), '0);
      chk("rst_done", K'(done), '0);
      chk("rst_sum",  sum,      '0);
      chk("rst_cout", K'(cout), '0);
    end else begin
      chk("busy", K'(busy), K'(m_left > 0));
      chk("done", K'(done), K'(m_done));
      if (m_left == 0) begin
        chk("sum",  sum,      m_sum);
        chk("cout", K'(cout), K'(m_cout));
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input string name, input logic [K-1:0] x, input logic [K-1:0] y,
                       input bit s, input logic [K-1:0] es, input bit ec);
    int n;
    @(posedge clk); #1;
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk({name, "_lat"},  K'(n), K'(NCHUNK));
    chk({name, "_sum"},  sum,   es);
    chk({name, "_cout"}, K'(cout), K'(ec));
  endtask

  initial begin
    int n, ndone, cyc;
    logic [K-1:0] ones, onesm1;
    ones   = '1;
    onesm1 = {{(K-1){1'b1}}, 1'b0};

    #23;
    chk("init_sum", sum, '0);
    chk("init_busy", K'(busy), '0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    do_op("all1_plus1", ones, K'(1), 1'b0, '0, 1'b1);
    do_op("5_minus_7", K'(5), K'(7), 1'b1, onesm1, 1'b0);
    do_op("7_minus_5", K'(7), K'(5), 1'b1, K'(2), 1'b1);
    do_op("chunk_carry", K'(64'h0000_0001_FFFF_FFFF), K'(1), 1'b0, K'(64'h2_0000_0000), 1'b0);
    do_op("0_minus_0", '0, '0, 1'b1, '0, 1'b1);
    do_op("0_minus_1", '0, K'(1), 1'b1, ones, 1'b0);

    // start pulsed in RUN cycles 2-5 must be ignored, operand changes too
    @(posedge clk); #1;
    a = K'(3); b = K'(4); sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = K'(999); b = K'(1); sub = 1'b1;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ndone++;
        chk("ign_sum", sum, K'(7));
      end
      @(posedge clk); #1;
    end
    chk("ign_ndone", K'(ndone), K'(1));

    // start held high through DONE gives a back-to-back op 9 cycles later
    @(posedge clk); #1;
    a = K'(3); b = K'(4); sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = K'(100); b = K'(58); sub = 1'b1;
    wait_done(n);
    chk("b2b_first_sum", sum, K'(7));
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_gap", K'(n), K'(NCHUNK + 1));
    chk("b2b_second_sum", sum, K'(42));
    chk("b2b_second_cout", K'(cout), K'(1));

    // reset in RUN cycle 4 aborts the op
    @(posedge clk); #1;
    a = ones; b = ones; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", K'(busy), '0);
    chk("abort_sum",  sum,      '0);
    chk("abort_cout", K'(cout), '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", K'(ndone), '0);
    do_op("after_abort", ones, ones, 1'b0, onesm1, 1'b1);

    // random back-to-back traffic, start held high, checked by the model
    ndone = 0;
    cyc   = 0;
    @(posedge clk); #1;
    while (ndone < NRAND && cyc < NRAND * (NCHUNK + 1) + 50) begin
      a = rand_k(); b = rand_k(); sub = $urandom_range(0, 1) == 1; start = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (done) ndone++;
    end
    start = 1'b0;
    chk("rand_ndone", K'(ndone), K'(NRAND));

    repeat (12) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
